// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches, buffers in-order
// responses with their PCs, and flushes and refetches on a branch/jump redirect.
module instr_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];

    logic [CW:0]   in_flight;
    logic [31:0]   redirect_target;
    logic          req_fire;
    logic          resp_fire;
    logic          push;
    logic          pop;

    // Credits cover both queued entries and requests still in flight, so a
    // returning response always has a free slot waiting for it.
    assign in_flight       = {1'b0, count} + {1'b0, outstanding};
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    assign imem_req_valid  = !reset && !redirect_valid && (in_flight < DEPTH_LIM);
    assign imem_req_addr   = fetch_pc;
    assign req_fire        = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding (e.g. one left over from before a
    // reset) has no matching request and is ignored.
    assign resp_fire       = imem_resp_valid && (outstanding != '0);
    assign push            = resp_fire && (drop == '0) && !redirect_valid;

    assign out_valid       = (count != '0) && !redirect_valid;
    assign out_instr       = instr_mem[rd_ptr];
    assign out_pc          = pc_mem[rd_ptr];
    assign pop             = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redirect_target;
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_fire);
        end
    end

    // Everything still in flight at a redirect is stale; a response landing
    // in the redirect cycle itself is already gone, so it is not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop    <= '0;
            resp_pc <= RESET_PC;
        end else if (redirect_valid) begin
            drop    <= outstanding - CW'(resp_fire);
            resp_pc <= redirect_target;
        end else begin
            if (resp_fire && (drop != '0)) begin
                drop <= drop - CW'(1);
            end
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (push) begin
            instr_mem[wr_ptr] <= imem_resp_data;
            pc_mem[wr_ptr]    <= resp_pc;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: a queue-based in-order memory model
// answers accepted fetches with data 32'h1000_0000 + address.
`timescale 1ns/1ps
module tb_instr_prefetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    int checks = 0;
    int errors = 0;
    int step_no = 0;
    bit mem_en;

    logic [31:0] mem_q[$];
    logic [31:0] req_q[$];
    logic [31:0] pop_pc_q[$];
    logic [31:0] pop_instr_q[$];
    int          pop_step_q[$];

    instr_prefetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    // One clock: sample handshakes before the edge, then the memory model
    // answers one queued request per cycle (1-cycle latency when enabled).
    task automatic step();
        logic        acc;
        logic [31:0] a;
        #2;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        if (out_valid && out_ready) begin
            pop_pc_q.push_back(out_pc);
            pop_instr_q.push_back(out_instr);
            pop_step_q.push_back(step_no);
        end
        @(posedge clk);
        #1;
        step_no++;
        if (acc) begin
            mem_q.push_back(a);
            req_q.push_back(a);
        end
        if (mem_en && mem_q.size() > 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'h1000_0000 + mem_q.pop_front();
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
    endtask

    task automatic hold_reset();
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        out_ready       = 1'b0;
        mem_en          = 1'b0;
        mem_q.delete();
        req_q.delete();
        pop_pc_q.delete();
        pop_instr_q.delete();
        pop_step_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        hold_reset();
        reset   = 1'b0;
        step_no = 0;
    endtask

    task automatic test_reset();
        hold_reset();
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
        checks++; if (imem_req_addr !== RESET_PC) begin errors++; $display("[TB] FAIL rst_req_addr: got %h expected %h", imem_req_addr, RESET_PC); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("[TB] FAIL rst_out_instr: got %h expected 0", out_instr); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_out_pc: got %h expected 0", out_pc); end
        reset = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_req_valid: got %b expected 1", imem_req_valid); end
        checks++; if (imem_req_addr !== RESET_PC) begin errors++; $display("[TB] FAIL first_req_addr: got %h expected %h", imem_req_addr, RESET_PC); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset();
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        mem_en         = 1'b1;
        repeat (8) step();
        checks++; if (pop_pc_q.size() < 4) begin errors++; $display("[TB] FAIL stream_pops: got %0d expected >=4", pop_pc_q.size()); end
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'(i * 4);
            checks++; if (qat(pop_pc_q, i) !== exp_pc) begin errors++; $display("[TB] FAIL stream_pc%0d: got %h expected %h", i, qat(pop_pc_q, i), exp_pc); end
            checks++; if (qat(pop_instr_q, i) !== 32'h1000_0000 + exp_pc) begin errors++; $display("[TB] FAIL stream_instr%0d: got %h expected %h", i, qat(pop_instr_q, i), 32'h1000_0000 + exp_pc); end
        end
        // Pops must land in consecutive cycles: first pop in cycle 2, then one per cycle.
        for (int i = 0; i < 4 && i < pop_step_q.size(); i++) begin
            checks++; if (pop_step_q[i] !== i + 2) begin errors++; $display("[TB] FAIL stream_cycle%0d: got %0d expected %0d", i, pop_step_q[i], i + 2); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        imem_req_ready = 1'b1;
        mem_en         = 1'b1;
        repeat (6) step();
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_valid: got %b expected 0", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h10) begin errors++; $display("[TB] FAIL bp_req_addr: got %h expected 00000010", imem_req_addr); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_out_valid: got %b expected 1", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("[TB] FAIL bp_out_pc: got %h expected 0", out_pc); end
        req_q.delete();
        out_ready = 1'b1;
        repeat (6) step();
        checks++; if (qat(req_q, 0) !== 32'h10) begin errors++; $display("[TB] FAIL bp_resume_addr: got %h expected 00000010", qat(req_q, 0)); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (qat(pop_pc_q, i) !== 32'(i * 4)) begin errors++; $display("[TB] FAIL bp_pc%0d: got %h expected %h", i, qat(pop_pc_q, i), 32'(i * 4)); end
        end
        checks++; if (qat(pop_instr_q, 3) !== 32'h1000_000C) begin errors++; $display("[TB] FAIL bp_instr3: got %h expected 1000000c", qat(pop_instr_q, 3)); end
    endtask

    task automatic test_redirect();
        do_reset();
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        repeat (2) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_req_valid: got %b expected 0", imem_req_valid); end
        step();
        redirect_valid = 1'b0;
        mem_en         = 1'b1;
        req_q.delete();
        repeat (8) step();
        checks++; if (qat(req_q, 0) !== 32'h100) begin errors++; $display("[TB] FAIL redir_req_addr: got %h expected 00000100", qat(req_q, 0)); end
        checks++; if (qat(pop_pc_q, 0) !== 32'h100) begin errors++; $display("[TB] FAIL redir_pc0: got %h expected 00000100", qat(pop_pc_q, 0)); end
        checks++; if (qat(pop_instr_q, 0) !== 32'h1000_0100) begin errors++; $display("[TB] FAIL redir_instr0: got %h expected 10000100", qat(pop_instr_q, 0)); end
        checks++; if (qat(pop_pc_q, 1) !== 32'h104) begin errors++; $display("[TB] FAIL redir_pc1: got %h expected 00000104", qat(pop_pc_q, 1)); end
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b1;
        mem_en    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin errors++; $display("[TB] FAIL stall_hold%0d: got valid=%b addr=%h expected valid=1 addr=%h", i, imem_req_valid, imem_req_addr, RESET_PC); end
            step();
        end
        checks++; if (req_q.size() !== 0) begin errors++; $display("[TB] FAIL stall_no_accept: got %0d expected 0", req_q.size()); end
        imem_req_ready = 1'b1;
        step();
        checks++; if (qat(req_q, 0) !== RESET_PC) begin errors++; $display("[TB] FAIL stall_accept_addr: got %h expected %h", qat(req_q, 0), RESET_PC); end
        checks++; if (imem_req_addr !== 32'h4) begin errors++; $display("[TB] FAIL stall_next_addr: got %h expected 00000004", imem_req_addr); end
    endtask

    task automatic test_async_reset();
        do_reset();
        imem_req_ready = 1'b1;
        mem_en         = 1'b1;
        repeat (4) step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("[TB] FAIL ar_pre: got valid=%b pc=%h expected valid=1 pc=0", out_valid, out_pc); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ar_out_valid: got %b expected 0", out_valid); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL ar_req_valid: got %b expected 0", imem_req_valid); end
        checks++; if (out_instr !== 32'h0 || out_pc !== 32'h0) begin errors++; $display("[TB] FAIL ar_out_data: got instr=%h pc=%h expected 0", out_instr, out_pc); end
        @(posedge clk);
        #1;
        mem_q.delete();
        pop_pc_q.delete();
        pop_instr_q.delete();
        mem_en          = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        reset           = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ar_late_resp: got %b expected 0", out_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin errors++; $display("[TB] FAIL ar_req_after: got valid=%b addr=%h expected valid=1 addr=%h", imem_req_valid, imem_req_addr, RESET_PC); end
        imem_req_ready = 1'b1;
        mem_en         = 1'b1;
        out_ready      = 1'b1;
        repeat (4) step();
        checks++; if (qat(pop_pc_q, 0) !== RESET_PC || qat(pop_instr_q, 0) !== 32'h1000_0000) begin errors++; $display("[TB] FAIL ar_refetch: got pc=%h instr=%h expected pc=%h instr=10000000", qat(pop_pc_q, 0), qat(pop_instr_q, 0), RESET_PC); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        do_reset();
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        mem_en         = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        repeat (7) step();
        for (int i = 0; i < 3; i++) begin
            checks++; if (qat(req_q, i) !== exp_pc[i]) begin errors++; $display("[TB] FAIL wrap_req%0d: got %h expected %h", i, qat(req_q, i), exp_pc[i]); end
            checks++; if (qat(pop_pc_q, i) !== exp_pc[i]) begin errors++; $display("[TB] FAIL wrap_pc%0d: got %h expected %h", i, qat(pop_pc_q, i), exp_pc[i]); end
        end
        checks++; if (qat(pop_instr_q, 2) !== 32'h1000_0000) begin errors++; $display("[TB] FAIL wrap_instr2: got %h expected 10000000", qat(pop_instr_q, 2)); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        repeat (2) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        redirect_pc     = 32'h0000_0300;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h1000_0000 + mem_q.pop_front();
        mem_en          = 1'b1;
        step();
        redirect_valid = 1'b0;
        req_q.delete();
        repeat (8) step();
        checks++; if (qat(req_q, 0) !== 32'h300) begin errors++; $display("[TB] FAIL b2b_req_addr: got %h expected 00000300", qat(req_q, 0)); end
        checks++; if (qat(pop_pc_q, 0) !== 32'h300) begin errors++; $display("[TB] FAIL b2b_pc0: got %h expected 00000300", qat(pop_pc_q, 0)); end
        checks++; if (qat(pop_instr_q, 0) !== 32'h1000_0300) begin errors++; $display("[TB] FAIL b2b_instr0: got %h expected 10000300", qat(pop_instr_q, 0)); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_stall();
        test_async_reset();
        test_wrap();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
